// File: rtl/uart_parser_pkg.sv
// Shared types and constants for the UART frame parser: FSM state
// encoding, error codes and the frame sync byte.
package uart_parser_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LEN  = 3'd1,
    ST_DATA = 3'd2,
    ST_CSUM = 3'd3,
    ST_EMIT = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_OVERRUN  = 2'b00,
    ERR_BAD_LEN  = 2'b01,
    ERR_BAD_CSUM = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } err_code_e;

endpackage

// File: rtl/uart_idle_timer.sv
// Inter-byte idle timer. Counts cycles without a kick while run is high and
// flags expiry on the cycle the count would reach TIMEOUT_CYCLES. A kick in
// that same cycle wins, so expiry never coincides with an accepted byte.
module uart_idle_timer #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic kick,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Expiry detection and next count; the counter parks at 0 when not running.
  always_comb begin
    expired = run && !kick && (cnt_q == LAST_CNT);
    if (!run || kick || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// UART frame parser: SYNC(0xA5), LEN, LEN payload bytes, CSUM (XOR of LEN
// and payload). Valid frames are replayed on a valid/ready output stream.
// Optional statistics counters are built when UART_PARSER_STATS_EN is defined.
//
// Output handshake: a byte transfers on a rising edge where out_valid and
// out_ready are both high; while out_valid=1 and out_ready=0, out_byte and
// out_last hold their values; out_valid never drops without a transfer
// except on reset.
module uart_frame_parser
  import uart_parser_pkg::*;
#(
  parameter int MAX_LEN        = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic [7:0]  out_byte,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        frame_ok,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt,
  output state_e      dbg_state
);

  localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  state_e      state_q, state_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  wr_idx_q, wr_idx_d;
  logic [7:0]  rd_idx_q, rd_idx_d;
  logic [7:0]  csum_q, csum_d;
  logic        frame_ok_q, frame_ok_d;
  logic        err_q, err_d;
  err_code_e   err_code_q, err_code_d;
  logic        buf_we;
  logic        last_rd;
  logic        timer_run;
  logic        timer_expired;
  logic [7:0]  payload_buf [MAX_LEN];

  uart_idle_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .run     (timer_run),
    .kick    (byte_valid),
    .expired (timer_expired)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      wr_idx_q   <= '0;
      rd_idx_q   <= '0;
      csum_q     <= '0;
      frame_ok_q <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_OVERRUN;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wr_idx_q   <= wr_idx_d;
      rd_idx_q   <= rd_idx_d;
      csum_q     <= csum_d;
      frame_ok_q <= frame_ok_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // Payload storage; contents are only read after being written this frame.
  always_ff @(posedge clk) begin
    if (buf_we) begin
      payload_buf[wr_idx_q[IW-1:0]] <= byte_in;
    end
  end

  // Next-state logic: frame parsing, checks, timeout and output indexing.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wr_idx_d   = wr_idx_q;
    rd_idx_d   = rd_idx_q;
    csum_d     = csum_q;
    frame_ok_d = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    buf_we     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (byte_valid && (byte_in == SYNC_BYTE)) begin
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (timer_expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else if (byte_valid) begin
          if ((byte_in == 8'd0) || (byte_in > MAX_LEN_B)) begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_LEN;
            state_d    = ST_IDLE;
          end else begin
            len_d    = byte_in;
            csum_d   = byte_in;
            wr_idx_d = '0;
            state_d  = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (timer_expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else if (byte_valid) begin
          // Payload bytes are taken verbatim, a sync value here does not resync.
          buf_we   = 1'b1;
          csum_d   = csum_q ^ byte_in;
          wr_idx_d = wr_idx_q + 8'd1;
          if (wr_idx_q == (len_q - 8'd1)) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (timer_expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ST_IDLE;
        end else if (byte_valid) begin
          if (byte_in == csum_q) begin
            frame_ok_d = 1'b1;
            rd_idx_d   = '0;
            state_d    = ST_EMIT;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_BAD_CSUM;
            state_d    = ST_IDLE;
          end
        end
      end
      ST_EMIT: begin
        // Input bytes cannot be stored while replaying; flag and drop them.
        if (byte_valid) begin
          err_d      = 1'b1;
          err_code_d = ERR_OVERRUN;
        end
        if (out_ready) begin
          if (last_rd) begin
            rd_idx_d = '0;
            state_d  = ST_IDLE;
          end else begin
            rd_idx_d = rd_idx_q + 8'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from registered state.
  always_comb begin
    out_valid = (state_q == ST_EMIT);
    last_rd   = (rd_idx_q == (len_q - 8'd1));
    out_last  = out_valid && last_rd;
    out_byte  = out_valid ? payload_buf[rd_idx_q[IW-1:0]] : 8'h00;
    timer_run = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
  end

  assign frame_ok  = frame_ok_q;
  assign err       = err_q;
  assign err_code  = err_code_q;
  assign dbg_state = state_q;

`ifdef UART_PARSER_STATS_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating counts of frame_ok and err pulses.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (frame_ok_q && (frame_cnt_q != 16'hFFFF)) frame_cnt_d = frame_cnt_q + 16'd1;
    if (err_q && (err_cnt_q != 16'hFFFF))        err_cnt_d   = err_cnt_q + 16'd1;
  end

  // Statistics registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign err_cnt   = err_cnt_q;
`else
  assign frame_cnt = 16'h0000;
  assign err_cnt   = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: directed frames plus randomized
// frames whose expected outcome is derived from the frame format rules.
module tb_uart_frame_parser;
  import uart_parser_pkg::*;

  localparam int MAX_LEN = 8;
  localparam int TMO     = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        out_ready;
  logic [7:0]  out_byte;
  logic        out_valid;
  logic        out_last;
  logic        frame_ok;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
  state_e      dbg_state;

  int n_total = 0;
  int n_bad   = 0;

  logic [8:0] exp_q[$];
  logic [7:0] tx_q[$];

  int exp_ok_total  = 0;
  int exp_err_total = 0;
  int obs_ok_total  = 0;
  int obs_err_total = 0;
  int exp_frame_cnt = 0;
  int exp_err_cnt   = 0;

  logic       prev_hold = 1'b0;
  logic [7:0] prev_byte = 8'h00;
  logic       prev_last = 1'b0;

  // Clock.
  always #5 clk = ~clk;

  uart_frame_parser #(
    .MAX_LEN        (MAX_LEN),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .out_byte   (out_byte),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_last   (out_last),
    .frame_ok   (frame_ok),
    .err        (err),
    .err_code   (err_code),
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: output stream, hold stability and pulse counting.
  always @(negedge clk) begin
    if (reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_byte", 32'(out_byte), 32'(prev_byte));
        check("hold_last", 32'(out_last), 32'(prev_last));
      end
      if (frame_ok) obs_ok_total++;
      if (err) obs_err_total++;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_extra_valid", 32'(out_valid), 32'd0);
        end else begin
          check("out_data", 32'({out_last, out_byte}), 32'(exp_q.pop_front()));
        end
      end
      prev_hold = out_valid && !out_ready;
      prev_byte = out_byte;
      prev_last = out_last;
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_in    = b;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic send_tx(input int gap_max);
    while (tx_q.size() > 0) begin
      if (gap_max > 0) idle($urandom_range(0, gap_max));
      send_byte(tx_q.pop_front());
    end
  endtask

  task automatic expect_ok(input string tag);
    check({tag, "_frame_ok"}, 32'(frame_ok), 32'd1);
    check({tag, "_no_err"}, 32'(err), 32'd0);
    exp_ok_total++;
    exp_frame_cnt++;
  endtask

  task automatic expect_err(input string tag, input logic [1:0] code);
    check({tag, "_err"}, 32'(err), 32'd1);
    check({tag, "_err_code"}, 32'(err_code), 32'(code));
    check({tag, "_no_ok"}, 32'(frame_ok), 32'd0);
    exp_err_total++;
    exp_err_cnt++;
  endtask

  // mode 0: always ready, 1: random ready, 2: ready once every 6 cycles
  task automatic drain(input int mode);
    int k = 0;
    while (exp_q.size() > 0 && k < 3000) begin
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = ((k % 6) == 5);
      endcase
      @(posedge clk);
      #1;
      k++;
    end
    out_ready = 1'b0;
    check("drain_left", 32'(exp_q.size()), 32'd0);
    check("drain_idle", 32'(out_valid), 32'd0);
  endtask

  // Builds a frame from the format rules; res: 0 good, 1 bad length, 2 bad checksum.
  task automatic build_frame(input logic [7:0] len, input bit corrupt, output int res);
    logic [7:0] csum;
    logic [7:0] b;
    logic [7:0] pl[$];
    tx_q.delete();
    tx_q.push_back(8'hA5);
    tx_q.push_back(len);
    if (len == 8'd0 || int'(len) > MAX_LEN) begin
      res = 1;
    end else begin
      csum = len;
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom);
        csum = csum ^ b;
        tx_q.push_back(b);
        pl.push_back(b);
      end
      if (corrupt) begin
        tx_q.push_back(csum ^ 8'($urandom_range(1, 255)));
        res = 2;
      end else begin
        tx_q.push_back(csum);
        for (int i = 0; i < int'(len); i++) exp_q.push_back({(i == int'(len) - 1), pl[i]});
        res = 0;
      end
    end
  endtask

  // Watchdog.
  initial begin
    #500000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1);
  end

  // Stimulus.
  initial begin
    int n;
    int res;
    int r;
    logic [7:0] len;
    logic [7:0] g;
    reset      = 1'b1;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    out_ready  = 1'b0;
    idle(3);
    reset = 1'b0;

    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_last", 32'(out_last), 32'd0);
    check("rst_out_byte", 32'(out_byte), 32'd0);
    check("rst_frame_ok", 32'(frame_ok), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Basic frame.
    tx_q  = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    exp_q = '{9'h011, 9'h022, 9'h133};
    send_tx(0);
    expect_ok("basic");
    drain(0);

    // Same frame with slow downstream.
    tx_q  = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    exp_q = '{9'h011, 9'h022, 9'h133};
    send_tx(0);
    expect_ok("slow");
    drain(2);

    // Bad checksum.
    tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
    send_tx(0);
    expect_err("csum", 2'b10);
    idle(3);
    check("csum_no_out", 32'(out_valid), 32'd0);

    // Bad lengths.
    tx_q = '{8'hA5, 8'h00};
    send_tx(0);
    expect_err("len0", 2'b01);
    check("len0_state", 32'(dbg_state), 32'(ST_IDLE));
    tx_q = '{8'hA5, 8'h09};
    send_tx(0);
    expect_err("len9", 2'b01);
    check("len9_state", 32'(dbg_state), 32'(ST_IDLE));

    // Timeout then recovery.
    tx_q = '{8'hA5, 8'h02, 8'h11};
    send_tx(0);
    n = 0;
    while (!err && n < 3 * TMO) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("tmo_cycles", 32'(n), 32'(TMO));
    check("tmo_code", 32'(err_code), 32'd3);
    check("tmo_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_err_total++;
    exp_err_cnt++;
    tx_q  = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
    exp_q = '{9'h17E};
    send_tx(0);
    expect_ok("after_tmo");
    drain(0);

    // Byte arriving on the would-be timeout cycle wins.
    tx_q = '{8'hA5, 8'h02};
    send_tx(0);
    exp_q = '{9'h011, 9'h122};
    idle(TMO - 1);
    send_byte(8'h11);
    idle(TMO - 1);
    send_byte(8'h22);
    send_byte(8'h02 ^ 8'h11 ^ 8'h22);
    expect_ok("byte_wins");
    drain(1);

    // Overrun during EMIT.
    tx_q  = '{8'hA5, 8'h01, 8'h55, 8'h54};
    exp_q = '{9'h155};
    send_tx(0);
    expect_ok("ovr_frame");
    idle(2);
    check("ovr_valid", 32'(out_valid), 32'd1);
    send_byte(8'h99);
    expect_err("overrun", 2'b00);
    check("ovr_byte", 32'(out_byte), 32'h55);
    drain(1);

    // Reset during EMIT after first handshake.
    tx_q  = '{8'hA5, 8'h03, 8'h0A, 8'h0B, 8'h0C, 8'h0E};
    exp_q = '{9'h00A, 9'h00B, 9'h10C};
    send_tx(0);
    expect_ok("rst_emit_frame");
    idle(1);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    reset     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_frame_cnt = 0;
    exp_err_cnt   = 0;
    check("rst_emit_valid", 32'(out_valid), 32'd0);
    check("rst_emit_last", 32'(out_last), 32'd0);
    check("rst_emit_frame_cnt", 32'(frame_cnt), 32'd0);
    check("rst_emit_err_cnt", 32'(err_cnt), 32'd0);
    check("rst_emit_state", 32'(dbg_state), 32'(ST_IDLE));
    out_ready = 1'b1;
    idle(5);
    out_ready = 1'b0;
    check("rst_emit_quiet", 32'(out_valid), 32'd0);

    // Randomized frames with leading garbage.
    repeat (30) begin
      repeat ($urandom_range(0, 3)) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h5A;
        idle($urandom_range(0, 2));
        send_byte(g);
      end
      r = $urandom_range(0, 9);
      if (r < 6) begin
        len = 8'($urandom_range(1, MAX_LEN));
        build_frame(len, 1'b0, res);
      end else if (r < 8) begin
        len = 8'($urandom_range(1, MAX_LEN));
        build_frame(len, 1'b1, res);
      end else begin
        len = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(MAX_LEN + 1, 255));
        build_frame(len, 1'b0, res);
      end
      send_tx(3);
      case (res)
        0: begin
          expect_ok("rnd");
          drain(1);
        end
        1:       expect_err("rnd_len", 2'b01);
        default: expect_err("rnd_csum", 2'b10);
      endcase
      idle($urandom_range(1, 4));
    end

    idle(4);
    check("total_frame_ok", 32'(obs_ok_total), 32'(exp_ok_total));
    check("total_err", 32'(obs_err_total), 32'(exp_err_total));
`ifdef UART_PARSER_STATS_EN
    check("stat_frame_cnt", 32'(frame_cnt), 32'(exp_frame_cnt));
    check("stat_err_cnt", 32'(err_cnt), 32'(exp_err_cnt));
`else
    check("stat_frame_cnt", 32'(frame_cnt), 32'd0);
    check("stat_err_cnt", 32'(err_cnt), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
